sub_divider_ctrl: RTL
=====================

# sub_divider_ctrl

Multi-cycle unsigned 32-bit divide controller for the CPU datapath. It sequences one `bla_subtractor32` through 32 restoring-division iterations, producing one quotient bit per cycle. It sits beside the ALU and is started by the execute stage for DIVU/REMU. It presents a start/ready/done handshake and holds its results until the next accepted start.

## Interface
- `ZERO_QUOT`, default 32'hFFFF_FFFF: quotient returned on divide-by-zero.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a divide; accepted only when `ready`=1.
- `dividend`  input  32  numerator; sampled on the accepting edge.
- `divisor`  input  32  denominator; sampled on the accepting edge.
- `ready`  output  1  high in IDLE and DONE; the block can accept `start`.
- `done`  output  1  one-cycle pulse; results valid.
- `quotient`  output  32  registered quotient.
- `remainder`  output  32  registered remainder.
- `div_zero`  output  1  registered; set when the last accepted divisor was 0.

## Operation
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset values: state=IDLE, `ready`=1, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, iteration count=0.
- IDLE/DONE with `start`=1:
  - Load the dividend shift register (Q) and divisor register (D), and clear the partial remainder (R).
  - Load `div_zero` = (divisor==0).
  - Go to RUN with count=0. If the divisor is 0, go directly to DONE instead.
- RUN, each edge:
  - Form S = {R[30:0], Q[31]}.
  - Subtractor inputs: a=S, b=D. It yields `diff` and `bout`.
  - qbit = R[31] | ~bout. When R[31]=1, the true 33-bit value exceeds any divisor, so the subtraction always succeeds and the low 32 bits of `diff` are exact.
  - R <= qbit ? diff : S.
  - Q <= {Q[30:0], qbit}.
  - count <= count+1.
  - After the edge where count==31, go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `quotient`=Q and `remainder`=R.
  - Next state is IDLE, or RUN/DONE if `start` is accepted this cycle (back-to-back operation).
- Divide-by-zero: `quotient`=ZERO_QUOT, `remainder`=dividend, `div_zero`=1.
- `start` during RUN is ignored and does not queue.
- Outputs `quotient`, `remainder` and `div_zero` hold from DONE until the next accepting edge.

## Timing
- Accepting edge E0. RUN occupies edges E1..E32. `done` is high in the cycle after E32, i.e. 33 cycles after the start is sampled.
- Divide-by-zero: `done` is high in the cycle after E0 (latency 1).
- `ready` is combinational from state. It is low throughout RUN.
- `done` is decoded from state=DONE and is never high in IDLE or RUN.
- Back-to-back: `start` asserted in the DONE cycle is accepted. `done` then drops next cycle and the new operation begins at once.
- `rst_n` low at any time, including mid-RUN: immediately return to reset values and discard the partial result. The first `start` after reset release is accepted normally.
- The subtractor path is a single-cycle ripple chain. A full R/Q update must close in one `clk` period.

## Structure
- Shared header `cpu_defs.vh`: state encodings `DIV_IDLE`=2'd0, `DIV_RUN`=2'd1, `DIV_DONE`=2'd2, and `DIV_ITER`=32.
- Sub-module: exactly one instance of the existing `bla_subtractor32` (ports bout, diff, a, b). Do not write a separate comparator.
- Datapath registers R, Q, D and the 5-bit count live in this block. The next-state logic is a single combinational block.

## Test plan
- 100 / 7: `done` 33 cycles after start; `quotient`=14, `remainder`=2, `div_zero`=0.
- 32'hFFFF_FFFF / 32'h8000_0001 (exercises the R[31] path): `quotient`=1, `remainder`=32'h7FFF_FFFE.
- 32'hFFFF_FFFF / 1 → `quotient`=32'hFFFF_FFFF, `remainder`=0. Also 3 / 10 → `quotient`=0, `remainder`=3.
- 5 / 0: `done` in the cycle after start; `quotient`=32'hFFFF_FFFF, `remainder`=5, `div_zero`=1.
- Start 100/7, pulse `start` with 9/2 at cycle 10: the second request is ignored and the result is still 14/2.
  - Then assert `start` with 9/2 in the DONE cycle: accepted back-to-back, giving 4/1 33 cycles later.
- Assert `rst_n`=0 at cycle 15 of a divide: all outputs return to 0 asynchronously and `ready`=1.
  - After release, 50/5 → `quotient`=10, `remainder`=0.

Source files
------------

// File: rtl/sub_divider_ctrl_pkg.sv
// Shared types and constants for the multi-cycle unsigned divider.
package sub_divider_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER = 32;
    localparam int CNT_W = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

endpackage

// File: rtl/bla_subtractor32.sv
// 32-bit ripple-borrow subtractor: diff = a - b, bout set when a < b.
module bla_subtractor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        bout
);

    logic br;

    always_comb begin
        br   = 1'b0;
        diff = '0;
        for (int i = 0; i < 32; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/sub_divider_ctrl.sv
// Restoring unsigned divider: one quotient bit per cycle through a
// single shared subtractor, start/ready/done handshake.
module sub_divider_ctrl
    import sub_divider_ctrl_pkg::*;
#(
    parameter logic [31:0] ZERO_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    div_state_e       state_q, state_d;
    logic [31:0]      r_q, r_d;
    logic [31:0]      q_q, q_d;
    logic [31:0]      d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [31:0] s;
    logic [31:0] diff;
    logic        bout;
    logic        qbit;

    assign s = {r_q[30:0], q_q[31]};
    // R[31] set means the 33-bit S exceeds any divisor.
    assign qbit = r_q[31] | ~bout;

    bla_subtractor32 u_sub (
        .a    (s),
        .b    (d_q),
        .diff (diff),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        unique case (state_q)
            DIV_RUN: begin
                r_d   = qbit ? diff : s;
                q_d   = {q_q[30:0], qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (start) begin
                    d_d   = divisor;
                    cnt_d = '0;
                    dz_d  = (divisor == '0);
                    if (divisor == '0) begin
                        q_d     = ZERO_QUOT;
                        r_d     = dividend;
                        state_d = DIV_DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        state_d = DIV_RUN;
                    end
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q != DIV_RUN);
        done  = (state_q == DIV_DONE);
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign div_zero  = dz_q;

endmodule
